// File: rtl/sb_io_bank_if.sv
`default_nettype none
// ============================================================================
// Module : sb_io_bank_if
// Fabric-side signal bundle of the sb_io_bank pad bank.
// Rev    : 1.0
// ============================================================================
interface sb_io_bank_if #(
    parameter int WIDTH = 8
);
    logic             clock_enable;
    logic             latch_input_value;
    logic [WIDTH-1:0] output_enable;
    logic [WIDTH-1:0] d_out_0;
    logic [WIDTH-1:0] d_out_1;
    logic [WIDTH-1:0] d_in_0;
    logic [WIDTH-1:0] d_in_1;

    modport master (
        output clock_enable, latch_input_value, output_enable, d_out_0, d_out_1,
        input  d_in_0, d_in_1
    );

    modport slave (
        input  clock_enable, latch_input_value, output_enable, d_out_0, d_out_1,
        output d_in_0, d_in_1
    );
endinterface
`default_nettype wire

// File: rtl/sb_io_bank.sv
`default_nettype none
// ============================================================================
// Module : sb_io_bank
// WIDTH-channel IO cell bank: SDR/DDR output, output enable, SDR/DDR input, input latch.
// Rev    : 1.0
// ============================================================================
module sb_io_bank #(
    parameter int WIDTH       = 8,
    parameter int OUT_MODE    = 1,
    parameter int OE_MODE     = 2,
    parameter int IN_MODE     = 1,
    parameter int IN_ALIGN    = 1,
    parameter int NEG_TRIGGER = 0
) (
    input  wire logic        clk,
    input  wire logic        reset,
    sb_io_bank_if.slave      bus,
    inout  wire [WIDTH-1:0]  package_pin
);

    logic             w_clk_p;
    logic             w_clk_d1;
    logic             w_clk_d2;
    logic             w_ce;
    logic             r_ce_q;
    logic [WIDTH-1:0] r_dq0, r_dq1, r_oe_q;
    logic [WIDTH-1:0] r_iq0, r_iq1, r_al0, r_al1, r_hold;
    logic [WIDTH-1:0] w_pad_in, w_iq0_nxt, w_al0_nxt, w_src0, w_src0_nxt;
    logic [WIDTH-1:0] w_pout, w_oe;

    assign w_clk_p  = (NEG_TRIGGER != 0) ? ~clk : clk;
    // DDR mux select lags the register clock by two deltas so dq0/dq1 settle first
    assign w_clk_d1 = w_clk_p;
    assign w_clk_d2 = w_clk_d1;
    assign w_ce     = (bus.clock_enable !== 1'b0);
    assign w_pad_in = package_pin;

    // Values D_IN_0's source takes after this primary edge; the hold copy tracks them
    assign w_iq0_nxt  = w_ce ? w_pad_in : r_iq0;
    assign w_al0_nxt  = w_ce ? r_iq0 : r_al0;
    assign w_src0_nxt = (IN_MODE == 0) ? w_pad_in :
                        ((IN_MODE == 2) && (IN_ALIGN != 0)) ? w_al0_nxt : w_iq0_nxt;

    always_ff @(posedge w_clk_p) begin
        if (reset) begin
            r_ce_q <= 1'b0;
            r_dq0  <= '0;
            r_dq1  <= '0;
            r_oe_q <= '0;
            r_iq0  <= '0;
            r_al0  <= '0;
            r_al1  <= '0;
            r_hold <= '0;
        end else begin
            r_ce_q <= w_ce;
            if (w_ce) begin
                r_dq0  <= bus.d_out_0;
                r_dq1  <= bus.d_out_1;
                r_oe_q <= bus.output_enable;
                r_iq0  <= w_pad_in;
                r_al0  <= r_iq0;
                r_al1  <= r_iq1;
            end
            if (!bus.latch_input_value) begin
                r_hold <= w_src0_nxt;
            end
        end
    end

    always_ff @(negedge w_clk_p) begin
        if (reset) begin
            r_iq1 <= '0;
        end else if (r_ce_q) begin
            r_iq1 <= w_pad_in;
        end
    end

    assign w_src0 = (IN_MODE == 0) ? w_pad_in :
                    ((IN_MODE == 2) && (IN_ALIGN != 0)) ? r_al0 : r_iq0;

    assign bus.d_in_0 = bus.latch_input_value ? r_hold : w_src0;
    assign bus.d_in_1 = (IN_MODE != 2) ? '0 : (IN_ALIGN != 0) ? r_al1 : r_iq1;

    assign w_pout = (OUT_MODE == 0) ? bus.d_out_0 :
                    (OUT_MODE == 2) ? (w_clk_d2 ? r_dq0 : r_dq1) :
                    (OUT_MODE == 3) ? ~r_dq0 : r_dq0;

    assign w_oe = (OE_MODE == 0) ? {WIDTH{1'b1}} :
                  (OE_MODE == 1) ? bus.output_enable :
                  (OE_MODE == 2) ? r_oe_q : {WIDTH{1'b0}};

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_pad
            assign package_pin[g] = w_oe[g] ? w_pout[g] : 1'bz;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sb_io_bank.sv
`default_nettype none
// ============================================================================
// Module : tb_sb_io_bank
// Randomized bench for sb_io_bank: six configurations share one stimulus stream.
// Rev    : 1.0
// ============================================================================
module tb_sb_io_bank;

    localparam int N     = 300;
    localparam int S_D0  = 0;
    localparam int S_D1  = 1;
    localparam int S_OE  = 2;
    localparam int S_PP  = 3;
    localparam int S_PN  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       s_ce, s_latch;
    logic [3:0] s_oe, s_d0, s_d1, pad_drv;

    tri0 [3:0] pad_a, pad_b, pad_c, pad_f;
    wire [3:0] pad_in;
    assign pad_in = pad_drv;

    sb_io_bank_if #(.WIDTH(4)) if_a ();
    sb_io_bank_if #(.WIDTH(4)) if_b ();
    sb_io_bank_if #(.WIDTH(4)) if_c ();
    sb_io_bank_if #(.WIDTH(4)) if_d ();
    sb_io_bank_if #(.WIDTH(4)) if_e ();
    sb_io_bank_if #(.WIDTH(4)) if_f ();

    assign {if_a.clock_enable, if_a.latch_input_value, if_a.output_enable, if_a.d_out_0, if_a.d_out_1} = {s_ce, s_latch, s_oe, s_d0, s_d1};
    assign {if_b.clock_enable, if_b.latch_input_value, if_b.output_enable, if_b.d_out_0, if_b.d_out_1} = {s_ce, s_latch, s_oe, s_d0, s_d1};
    assign {if_c.clock_enable, if_c.latch_input_value, if_c.output_enable, if_c.d_out_0, if_c.d_out_1} = {s_ce, s_latch, s_oe, s_d0, s_d1};
    assign {if_d.clock_enable, if_d.latch_input_value, if_d.output_enable, if_d.d_out_0, if_d.d_out_1} = {s_ce, s_latch, s_oe, s_d0, s_d1};
    assign {if_e.clock_enable, if_e.latch_input_value, if_e.output_enable, if_e.d_out_0, if_e.d_out_1} = {s_ce, s_latch, s_oe, s_d0, s_d1};
    assign {if_f.clock_enable, if_f.latch_input_value, if_f.output_enable, if_f.d_out_0, if_f.d_out_1} = {s_ce, s_latch, s_oe, s_d0, s_d1};

    sb_io_bank #(.WIDTH(4), .OUT_MODE(1), .OE_MODE(2), .IN_MODE(0), .IN_ALIGN(0), .NEG_TRIGGER(0))
        u_sdr  (.clk(clk), .reset(rst), .bus(if_a), .package_pin(pad_a));
    sb_io_bank #(.WIDTH(4), .OUT_MODE(2), .OE_MODE(0), .IN_MODE(1), .IN_ALIGN(0), .NEG_TRIGGER(0))
        u_ddr  (.clk(clk), .reset(rst), .bus(if_b), .package_pin(pad_b));
    sb_io_bank #(.WIDTH(4), .OUT_MODE(3), .OE_MODE(1), .IN_MODE(1), .IN_ALIGN(0), .NEG_TRIGGER(0))
        u_inv  (.clk(clk), .reset(rst), .bus(if_c), .package_pin(pad_c));
    sb_io_bank #(.WIDTH(4), .OUT_MODE(1), .OE_MODE(3), .IN_MODE(2), .IN_ALIGN(1), .NEG_TRIGGER(0))
        u_iddr (.clk(clk), .reset(rst), .bus(if_d), .package_pin(pad_in));
    sb_io_bank #(.WIDTH(4), .OUT_MODE(1), .OE_MODE(3), .IN_MODE(0), .IN_ALIGN(0), .NEG_TRIGGER(0))
        u_icmb (.clk(clk), .reset(rst), .bus(if_e), .package_pin(pad_in));
    sb_io_bank #(.WIDTH(4), .OUT_MODE(1), .OE_MODE(2), .IN_MODE(1), .IN_ALIGN(0), .NEG_TRIGGER(1))
        u_neg  (.clk(clk), .reset(rst), .bus(if_f), .package_pin(pad_f));

    // Per-cycle stimulus: index k is what the primary posedge k samples
    logic       rst_a   [0:N];
    logic       ce_a    [0:N];
    logic       latch_a [0:N];
    logic [3:0] oe_a    [0:N];
    logic [3:0] d0_a    [0:N];
    logic [3:0] d1_a    [0:N];
    logic [3:0] pp_a    [0:N];
    logic [3:0] pn_a    [0:N];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got %h exp %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [3:0] pick(input int sel, input int j);
        case (sel)
            S_D0:    return d0_a[j];
            S_D1:    return d1_a[j];
            S_OE:    return oe_a[j];
            S_PP:    return pp_a[j];
            default: return pn_a[j];
        endcase
    endfunction

    // Value of a CE-gated register after edge k: newest enabled sample since the last reset
    function automatic logic [3:0] held(input int sel, input int k);
        for (int j = k; j >= 0; j--) begin
            if (rst_a[j]) return 4'h0;
            if (ce_a[j])  return pick(sel, j);
        end
        return 4'h0;
    endfunction

    // Aligned DDR input stage: re-captures the first-stage value from the previous cycle
    function automatic logic [3:0] aligned(input int sel, input int k);
        for (int j = k; j >= 0; j--) begin
            if (rst_a[j]) return 4'h0;
            if (ce_a[j])  return (j == 0) ? 4'h0 : held(sel, j - 1);
        end
        return 4'h0;
    endfunction

    function automatic logic [3:0] hold_d(input int k);
        for (int j = k; j >= 0; j--) begin
            if (rst_a[j])    return 4'h0;
            if (!latch_a[j]) return aligned(S_PP, j);
        end
        return 4'h0;
    endfunction

    function automatic logic [3:0] hold_e(input int k);
        for (int j = k; j >= 0; j--) begin
            if (rst_a[j])    return 4'h0;
            if (!latch_a[j]) return pp_a[j];
        end
        return 4'h0;
    endfunction

    task automatic apply(input int k);
        rst     = rst_a[k];
        s_ce    = ce_a[k];
        s_latch = latch_a[k];
        s_oe    = oe_a[k];
        s_d0    = d0_a[k];
        s_d1    = d1_a[k];
        pad_drv = pp_a[k];
    endtask

    task automatic check_point(input int k, input logic hi);
        logic [3:0] pad_now;
        pad_now = hi ? pp_a[k] : pn_a[k];
        chk("sdr_pin", pad_a, held(S_D0, k) & held(S_OE, k));
        chk("ddr_pin", pad_b, hi ? held(S_D0, k) : held(S_D1, k));
        chk("inv_pin", pad_c, oe_a[k] & ~held(S_D0, k));
        if (!hi)
            chk("neg_pin_lo", pad_f, held(S_D0, k) & held(S_OE, k));
        else if (k > 0)
            chk("neg_pin_hi", pad_f, held(S_D0, k - 1) & held(S_OE, k - 1));
        chk("iddr_din0", if_d.d_in_0, latch_a[k] ? hold_d(k) : aligned(S_PP, k));
        chk("iddr_din1", if_d.d_in_1, aligned(S_PN, k));
        chk("icmb_din0", if_e.d_in_0, latch_a[k] ? hold_e(k) : pad_now);
    endtask

    initial begin
        for (int k = 0; k <= N; k++) begin
            rst_a[k]   = (k < 2) || ($urandom_range(0, 19) == 0);
            ce_a[k]    = ($urandom_range(0, 4) != 0);
            latch_a[k] = ($urandom_range(0, 3) == 0);
            oe_a[k]    = 4'($urandom);
            d0_a[k]    = 4'($urandom);
            d1_a[k]    = 4'($urandom);
            pp_a[k]    = 4'($urandom);
            pn_a[k]    = 4'($urandom);
        end
        latch_a[0] = 1'b0;
        // Bring-up: enable all pins with 4'hA / 4'hC, then freeze CE so the DDR pattern repeats
        for (int k = 2; k <= 6; k++) begin
            rst_a[k] = 1'b0; ce_a[k] = (k == 2) || (k == 6);
            oe_a[k] = 4'hF; d0_a[k] = (k == 6) ? 4'h5 : 4'hA; d1_a[k] = 4'hC;
        end
        rst_a[7] = 1'b1; ce_a[7] = 1'b1; rst_a[8] = 1'b0;
        // Latch hold while the pad moves 7 -> 2, then release
        for (int k = 10; k <= 13; k++) begin
            rst_a[k] = 1'b0; ce_a[k] = 1'b1;
            latch_a[k] = (k == 11) || (k == 12);
            pp_a[k] = (k == 10) ? 4'h7 : 4'h2; pn_a[k] = pp_a[k];
        end
        rst_a[30] = 1'b1; latch_a[30] = 1'b1; rst_a[31] = 1'b0; latch_a[31] = 1'b1;
        rst_a[40] = 1'b0; ce_a[40] = 1'b1; pp_a[40] = 4'h3; pn_a[40] = 4'h9;
        rst_a[41] = 1'b0; ce_a[41] = 1'b1; latch_a[41] = 1'b0;

        apply(0);
        for (int k = 0; k < N; k++) begin
            @(posedge clk); #1;
            check_point(k, 1'b1);
            #1 pad_drv = pn_a[k];
            @(negedge clk); #1;
            check_point(k, 1'b0);
            #1 apply(k + 1);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
